// File: rtl/urna_eletronica_pkg.sv
// Shared definitions for the electronic ballot box: state encoding,
// votoValido encodings, default candidate codes and tally geometry.
package urna_pkg;

   typedef enum logic [2:0] {
      DIG1   = 3'd0,
      DIG2   = 3'd1,
      DIG3   = 3'd2,
      DIG4   = 3'd3,
      CONF   = 3'd4,
      COUNT  = 3'd5,
      CLOSED = 3'd6
   } estado_t;

   localparam logic [1:0] VV_INCOMPLETO = 2'b00;
   localparam logic [1:0] VV_VALIDO     = 2'b01;
   localparam logic [1:0] VV_NULO       = 2'b10;

   localparam logic [15:0] DEF_CODE_ARTHUR  = 16'h1101;
   localparam logic [15:0] DEF_CODE_LEANDRO = 16'h2202;
   localparam logic [15:0] DEF_CODE_MATEUS  = 16'h3480;
   localparam logic [15:0] DEF_CODE_PABLO   = 16'h5505;

   // four candidates plus nulo, six BCD digits each
   localparam int N_CAND = 5;
   localparam int N_DIG  = 6;

   // true when the keypad value is a decimal digit
   function automatic logic is_bcd(input logic [3:0] d);
      return d <= 4'd9;
   endfunction

endpackage

// File: rtl/urna_eletronica_contador_bcd.sv
// One decade of a BCD counter; decades are chained through carry.
module contador_bcd (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   output logic [3:0] valor,
   output logic       carry
);

   // the next decade steps when this one is enabled and rolls 9 -> 0
   assign carry = en & (valor == 4'd9);

   // decade register: counts 0..9 and wraps
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         valor <= 4'd0;
      else if (en)
         valor <= (valor == 4'd9) ? 4'd0 : valor + 4'd1;
   end

endmodule

// File: rtl/urna_eletronica.sv
// Ballot box top: keypad strobe edge detect, vote-entry FSM, code compare
// and per-candidate 6-digit BCD tallies.
module urna_eletronica
   import urna_pkg::*;
#(
   parameter logic [15:0] CODE_ARTHUR  = DEF_CODE_ARTHUR,
   parameter logic [15:0] CODE_LEANDRO = DEF_CODE_LEANDRO,
   parameter logic [15:0] CODE_MATEUS  = DEF_CODE_MATEUS,
   parameter logic [15:0] CODE_PABLO   = DEF_CODE_PABLO
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  digit,
   input  logic        valid,
   input  logic        confirma,
   input  logic        finish,
   output logic [2:0]  estado,
   output logic [2:0]  next_estado,
   output logic [3:0]  digito1,
   output logic [3:0]  digito2,
   output logic [3:0]  digito3,
   output logic [3:0]  digito4,
   output logic [1:0]  votoValido,
   output logic        candidatoArthur,
   output logic        candidatoLeandro,
   output logic        candidatoMateus,
   output logic        candidatoPablo,
   output logic        candidatoNulo,
   output logic [23:0] tally_arthur,
   output logic [23:0] tally_leandro,
   output logic [23:0] tally_mateus,
   output logic [23:0] tally_pablo,
   output logic [23:0] tally_nulo
);

   estado_t     st, st_nxt;
   logic        valid_q, stb;
   logic        ld, clr;
   logic [15:0] code;
   logic        match;
   logic [N_CAND-1:0]             pulso;
   logic [N_CAND-1:0][N_DIG:0]    en;
   logic [N_CAND-1:0][N_DIG-1:0][3:0] val;

   assign stb         = valid & ~valid_q;
   assign estado      = st;
   assign next_estado = st_nxt;
   assign code        = {digito1, digito2, digito3, digito4};
   assign match       = (code == CODE_ARTHUR) || (code == CODE_LEANDRO) ||
                        (code == CODE_MATEUS) || (code == CODE_PABLO);

   // keypad level delayed one clock for rising-edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         valid_q <= 1'b0;
      else
         valid_q <= valid;
   end

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         st <= DIG1;
      else
         st <= st_nxt;
   end

   // next state plus digit latch/clear requests; finish overrides all but COUNT
   always_comb begin
      st_nxt = st;
      ld     = 1'b0;
      clr    = 1'b0;
      case (st)
         DIG1, DIG2, DIG3, DIG4: begin
            if (stb && !confirma && is_bcd(digit)) begin
               ld     = 1'b1;
               st_nxt = (st == DIG4) ? CONF : estado_t'(st + 3'd1);
            end
         end
         CONF: begin
            if (stb) begin
               if (confirma) begin
                  st_nxt = COUNT;
               end else begin
                  st_nxt = DIG1;
                  clr    = 1'b1;
               end
            end
         end
         COUNT: begin
            st_nxt = DIG1;
            clr    = 1'b1;
         end
         CLOSED: st_nxt = CLOSED;
         default: st_nxt = DIG1;
      endcase
      if (finish && st != COUNT) begin
         st_nxt = CLOSED;
         ld     = 1'b0;
         clr    = 1'b0;
      end
   end

   // digit registers, filled in entry order
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         digito1 <= 4'd0;
         digito2 <= 4'd0;
         digito3 <= 4'd0;
         digito4 <= 4'd0;
      end else if (clr) begin
         digito1 <= 4'd0;
         digito2 <= 4'd0;
         digito3 <= 4'd0;
         digito4 <= 4'd0;
      end else if (ld) begin
         case (st)
            DIG1:    digito1 <= digit;
            DIG2:    digito2 <= digit;
            DIG3:    digito3 <= digit;
            DIG4:    digito4 <= digit;
            default: ;
         endcase
      end
   end

   // vote classification, only meaningful once all four digits are in
   always_comb begin
      votoValido = VV_INCOMPLETO;
      if (st == CONF || st == COUNT)
         votoValido = match ? VV_VALIDO : VV_NULO;
   end

   assign candidatoArthur  = (st == COUNT) && (code == CODE_ARTHUR);
   assign candidatoLeandro = (st == COUNT) && (code == CODE_LEANDRO);
   assign candidatoMateus  = (st == COUNT) && (code == CODE_MATEUS);
   assign candidatoPablo   = (st == COUNT) && (code == CODE_PABLO);
   assign candidatoNulo    = (st == COUNT) && !match;

   assign pulso = {candidatoNulo, candidatoPablo, candidatoMateus,
                   candidatoLeandro, candidatoArthur};

   // each tally is a ripple-enabled chain of BCD decades
   for (genvar c = 0; c < N_CAND; c++) begin : g_cand
      assign en[c][0] = pulso[c];
      for (genvar d = 0; d < N_DIG; d++) begin : g_dig
         contador_bcd u_dig (
            .clock (clock),
            .reset (reset),
            .en    (en[c][d]),
            .valor (val[c][d]),
            .carry (en[c][d+1])
         );
      end
   end

   assign tally_arthur  = val[0];
   assign tally_leandro = val[1];
   assign tally_mateus  = val[2];
   assign tally_pablo   = val[3];
   assign tally_nulo    = val[4];

endmodule

// File: tb/tb_urna_eletronica.sv
// Scoreboard bench for the ballot box: stimulus pushes expected vote
// winners, a negedge monitor pops them when a pulse appears.
module tb_urna_eletronica;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  digit = 4'd0;
   logic        valid = 1'b0;
   logic        confirma = 1'b0;
   logic        finish = 1'b0;
   logic [2:0]  estado, next_estado;
   logic [3:0]  digito1, digito2, digito3, digito4;
   logic [1:0]  votoValido;
   logic        candidatoArthur, candidatoLeandro, candidatoMateus;
   logic        candidatoPablo, candidatoNulo;
   logic [23:0] tally_arthur, tally_leandro, tally_mateus, tally_pablo, tally_nulo;

   urna_eletronica dut (
      .clock(clock), .reset(reset), .digit(digit), .valid(valid),
      .confirma(confirma), .finish(finish), .estado(estado),
      .next_estado(next_estado), .digito1(digito1), .digito2(digito2),
      .digito3(digito3), .digito4(digito4), .votoValido(votoValido),
      .candidatoArthur(candidatoArthur), .candidatoLeandro(candidatoLeandro),
      .candidatoMateus(candidatoMateus), .candidatoPablo(candidatoPablo),
      .candidatoNulo(candidatoNulo), .tally_arthur(tally_arthur),
      .tally_leandro(tally_leandro), .tally_mateus(tally_mateus),
      .tally_pablo(tally_pablo), .tally_nulo(tally_nulo)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // reference model state
   int ent[$];          // digits accepted so far
   bit closed = 1'b0;
   int cnt[5];          // votes per candidate (0..3) and nulo (4)
   int sb[$];           // expected winners, in order
   int pend = -1;       // candidate whose tally is due for checking

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int cand_of(input logic [15:0] c);
      if (c == 16'h1101) return 0;
      if (c == 16'h2202) return 1;
      if (c == 16'h3480) return 2;
      if (c == 16'h5505) return 3;
      return 4;
   endfunction

   function automatic logic [23:0] bcd6(input int n);
      logic [23:0] r;
      int v;
      v = n % 1000000;
      for (int i = 0; i < 6; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [23:0] get_tally(input int i);
      case (i)
         0: return tally_arthur;
         1: return tally_leandro;
         2: return tally_mateus;
         3: return tally_pablo;
         default: return tally_nulo;
      endcase
   endfunction

   function automatic logic [15:0] mk_code();
      return {ent[0][3:0], ent[1][3:0], ent[2][3:0], ent[3][3:0]};
   endfunction

   // monitor: every pulse must match the next expected winner
   always @(negedge clock) begin
      logic [4:0] pul;
      int e;
      if (reset) begin
         if (pend >= 0) begin
            chk($sformatf("tally%0d", pend), get_tally(pend), bcd6(cnt[pend]));
            pend = -1;
         end
         pul = {candidatoNulo, candidatoPablo, candidatoMateus,
                candidatoLeandro, candidatoArthur};
         if (pul != 5'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", pul, 5'b0);
            end else begin
               e = sb.pop_front();
               chk("pulse", pul, 5'b1 << e);
               cnt[e]++;
               pend = e;
            end
         end
      end
   end

   task automatic model_clear();
      ent.delete();
      sb.delete();
      closed = 1'b0;
      pend = -1;
      for (int i = 0; i < 5; i++) cnt[i] = 0;
   endtask

   // one keypad press, valid held for 'hold' cycles
   task automatic press(input int d, input bit c, input int hold);
      int exp_st;
      logic [1:0] exp_vv;
      int cnd;
      @(negedge clock);
      digit = 4'(d);
      confirma = c;
      valid = 1'b1;
      exp_vv = 2'b00;
      if (closed) begin
         exp_st = 6;
      end else if (ent.size() < 4) begin
         if (!c && d <= 9) ent.push_back(d);
         exp_st = ent.size();
         if (exp_st == 4) exp_vv = (cand_of(mk_code()) < 4) ? 2'b01 : 2'b10;
      end else if (c) begin
         cnd = cand_of(mk_code());
         sb.push_back(cnd);
         exp_st = 5;
         exp_vv = (cnd < 4) ? 2'b01 : 2'b10;
         ent.delete();
      end else begin
         exp_st = 0;
         ent.delete();
      end
      repeat (hold) @(negedge clock);
      valid = 1'b0;
      chk("estado", estado, exp_st);
      chk("votoValido", votoValido, exp_vv);
      if (exp_st == 5) begin
         @(negedge clock);
         chk("estado_after_count", estado, 0);
         chk("digits_cleared", {digito1, digito2, digito3, digito4}, 16'h0);
      end
   endtask

   task automatic vote(input logic [15:0] code, input bit conf, input bit junk);
      for (int i = 3; i >= 0; i--) begin
         if (junk && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) press($urandom_range(10, 15), 1'b0, 1);
            else press($urandom_range(0, 9), 1'b1, 1);
         end
         press(int'(code[i*4 +: 4]), 1'b0, 1);
      end
      press($urandom_range(0, 15), conf, 1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_clear();
      repeat (2) begin
         @(negedge clock); valid = 1'b1;
         @(negedge clock); valid = 1'b0;
      end
      chk("rst_estado", estado, 0);
      chk("rst_digits", {digito1, digito2, digito3, digito4}, 16'h0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   logic [15:0] rcode;
   int k;

   initial begin
      do_reset();
      chk("reset_estado", estado, 0);
      chk("reset_vv", votoValido, 2'b00);
      for (int i = 0; i < 5; i++) chk("reset_tally", get_tally(i), 24'h0);

      // Mateus vote, then a nulo vote
      vote(16'h3480, 1'b1, 1'b0);
      @(negedge clock);
      chk("tally_mateus_1", tally_mateus, 24'h000001);
      chk("tally_arthur_0", tally_arthur, 24'h0);
      vote(16'h9999, 1'b1, 1'b0);
      @(negedge clock);
      chk("tally_nulo_1", tally_nulo, 24'h000001);

      // entry edge cases: early confirm, out-of-range digit, cancel
      press(3, 1'b0, 1);
      press(4, 1'b0, 1);
      press(5, 1'b1, 1);
      press(12, 1'b0, 1);
      press(8, 1'b0, 1);
      press(0, 1'b0, 1);
      press(7, 1'b0, 1);
      chk("cancel_digits", {digito1, digito2, digito3, digito4}, 16'h0);

      // long hold gives one digit, then ten Arthur votes
      press(1, 1'b0, 50);
      press(1, 1'b0, 1);
      press(0, 1'b0, 1);
      press(1, 1'b0, 1);
      press(0, 1'b1, 1);
      repeat (9) vote(16'h1101, 1'b1, 1'b0);
      @(negedge clock);
      chk("tally_arthur_10", tally_arthur, 24'h000010);

      // randomized votes with junk presses and cancellations
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 5);
         case (k)
            0: rcode = 16'h1101;
            1: rcode = 16'h2202;
            2: rcode = 16'h3480;
            3: rcode = 16'h5505;
            default: rcode = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         endcase
         vote(rcode, (k != 5), 1'b1);
      end
      @(negedge clock);
      for (int i = 0; i < 5; i++) chk("tally_final", get_tally(i), bcd6(cnt[i]));

      // finish mid-entry closes the election
      press(2, 1'b0, 1);
      @(negedge clock);
      finish = 1'b1;
      closed = 1'b1;
      @(negedge clock);
      chk("closed", estado, 6);
      finish = 1'b0;
      vote(16'h5505, 1'b1, 1'b0);
      chk("still_closed", estado, 6);

      // asynchronous reset mid-entry
      do_reset();
      press(5, 1'b0, 1);
      press(5, 1'b0, 1);
      #2 reset = 1'b0;
      model_clear();
      #1 chk("async_rst_estado", estado, 0);
      chk("async_rst_digits", {digito1, digito2, digito3, digito4}, 16'h0);
      @(negedge clock);
      reset = 1'b1;
      vote(16'h2202, 1'b1, 1'b0);
      @(negedge clock);
      chk("tally_leandro_1", tally_leandro, 24'h000001);
      chk("tally_pablo_0", tally_pablo, 24'h0);

      repeat (3) @(negedge clock);
      chk("missing_pulses", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
